// File: rtl/updi_frame_packer.sv
// Packs CG_FSM bytes into 12-bit UPDI frames in BUFF_MEM and hands the buffer to the PHY.
// Optional BREAK word injection is enabled by defining UPDI_PACKER_BREAK_EN.
module updi_frame_packer #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_trans_en,
`ifdef UPDI_PACKER_BREAK_EN
  input  logic              i_break,
`endif
  output logic              o_csb0,
  output logic              o_web0,
  output logic [ADDR_W-1:0] o_addr0,
  output logic [11:0]       o_din0,
  output logic              o_ten,
  input  logic              i_tend,
  output logic [ADDR_W:0]   o_len,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StTx    = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic              pending_q, pending_d;
  logic              ready_d, csb_d, web_d, ten_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [11:0]       din_d;
  logic [ADDR_W:0]   wptr_inc;
  logic [11:0]       frame;
  logic              take_byte, take_break;

  // Start bit first, then data LSB-first, even parity, two stop bits.
  assign frame    = {2'b11, ^i_data, i_data, 1'b0};
  assign wptr_inc = wptr_q + 1'b1;

`ifdef UPDI_PACKER_BREAK_EN
  assign take_break = i_break && o_ready && (state_q == StIdle);
  assign take_byte  = i_valid && o_ready && !i_break;
`else
  assign take_break = 1'b0;
  assign take_byte  = i_valid && o_ready;
`endif

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    pending_d = pending_q;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    addr_d    = o_addr0;
    din_d     = o_din0;
    ten_d     = o_ten;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (take_break || take_byte) begin
          state_d = StWrite;
          din_d   = take_break ? 12'h000 : frame;
          addr_d  = wptr_q[ADDR_W-1:0];
          csb_d   = 1'b0;
          web_d   = 1'b0;
          if (i_trans_en) pending_d = 1'b1;
        end else if (i_trans_en && (wptr_q != '0)) begin
          state_d = StTx;
          ten_d   = 1'b1;
        end
      end
      StWrite: begin
        wptr_d = wptr_inc;
        // Pending request or a full buffer both start transmission right away.
        if (pending_q || (wptr_inc == DepthW)) begin
          state_d   = StTx;
          ten_d     = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StTx: begin
        if (i_tend) begin
          state_d = StDone;
          ten_d   = 1'b0;
          done_d  = 1'b1;
          wptr_d  = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) && (wptr_d < DepthW) && !pending_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      pending_q <= 1'b0;
      o_ready   <= 1'b0;
      o_csb0    <= 1'b1;
      o_web0    <= 1'b1;
      o_addr0   <= '0;
      o_din0    <= '0;
      o_ten     <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      pending_q <= pending_d;
      o_ready   <= ready_d;
      o_csb0    <= csb_d;
      o_web0    <= web_d;
      o_addr0   <= addr_d;
      o_din0    <= din_d;
      o_ten     <= ten_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
    end
  end

  assign o_len = wptr_q;

endmodule
